// File: rtl/grant_data_mux.sv
// grant_data_mux: captures the granted requester's payload into a one-entry output register
module grant_data_mux #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt3,
    input  logic          gnt2,
    input  logic          gnt1,
    input  logic          gnt0,
    input  logic [DW-1:0] din3,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din0,
    input  logic          out_ready,
    input  logic          cnt_clr,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src,
    output logic          ack3,
    output logic          ack2,
    output logic          ack1,
    output logic          ack0,
    output logic [CW-1:0] cnt3,
    output logic [CW-1:0] cnt2,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt0,
    output logic          err
);
    logic [2:0]    n_gnt;
    logic          onehot;
    logic          multi;
    logic          fire;
    logic          space;
    logic          capture;
    logic [1:0]    idx;
    logic [DW-1:0] sel_data;
    logic [3:0]    ack;
    logic [CW-1:0] cnt [4];

    // Decode the grant vector into a source index and capture/drain conditions
    always_comb begin
        n_gnt    = {2'b0, gnt0} + {2'b0, gnt1} + {2'b0, gnt2} + {2'b0, gnt3};
        onehot   = n_gnt == 3'd1;
        multi    = n_gnt > 3'd1;
        fire     = out_valid & out_ready;
        space    = !out_valid | out_ready;
        capture  = onehot & space;
        idx      = gnt3 ? 2'd3 : gnt2 ? 2'd2 : gnt1 ? 2'd1 : 2'd0;
        sel_data = gnt3 ? din3 : gnt2 ? din2 : gnt1 ? din1 : din0;
    end

    // Output register: a new beat may replace a firing one in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ack       <= 4'd0;
        end else begin
            ack <= capture ? 4'd1 << idx : 4'd0;
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= idx;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating per-source transfer counters and sticky multi-hot flag; clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            err <= 1'b0;
        end else if (cnt_clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            err <= 1'b0;
        end else begin
            if (multi) err <= 1'b1;
            if (fire && cnt[out_src] != {CW{1'b1}}) cnt[out_src] <= cnt[out_src] + 1'b1;
        end
    end

    assign {ack3, ack2, ack1, ack0} = ack;
    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];
endmodule

// File: tb/tb_grant_data_mux.sv
// tb_grant_data_mux: directed checks of capture, backpressure, multi-hot, counters and reset
module tb_grant_data_mux;
    logic       clk = 1'b0;
    logic       rst;
    logic       gnt3, gnt2, gnt1, gnt0;
    logic [7:0] din3, din2, din1, din0;
    logic       out_ready, cnt_clr;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic       ack3, ack2, ack1, ack0;
    logic [1:0] cnt3, cnt2, cnt1, cnt0;
    logic       err;
    int checks = 0;
    int errors = 0;

    grant_data_mux #(.DW(8), .CW(2)) dut (
        .clk(clk), .rst(rst),
        .gnt3(gnt3), .gnt2(gnt2), .gnt1(gnt1), .gnt0(gnt0),
        .din3(din3), .din2(din2), .din1(din1), .din0(din0),
        .out_ready(out_ready), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .ack3(ack3), .ack2(ack2), .ack1(ack1), .ack0(ack0),
        .cnt3(cnt3), .cnt2(cnt2), .cnt1(cnt1), .cnt0(cnt0),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gnt(input logic [3:0] g);
        {gnt3, gnt2, gnt1, gnt0} = g;
    endtask

    initial begin
        rst = 1'b0;
        set_gnt(4'b0000);
        {din3, din2, din1, din0} = '0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ack", {ack3, ack2, ack1, ack0}, 0);
        chk("rst_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // single grant
        set_gnt(4'b0001); din0 = 8'hA5; out_ready = 1'b1;
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_src", out_src, 0);
        chk("single_ack", {ack3, ack2, ack1, ack0}, 4'b0001);
        set_gnt(4'b0000);
        tick();
        chk("single_drain", out_valid, 0);
        chk("single_ack_off", {ack3, ack2, ack1, ack0}, 0);
        chk("single_cnt0", cnt0, 1);

        // rotating grants
        set_gnt(4'b0001); din0 = 8'h11;
        tick();
        chk("rot0_data", out_data, 8'h11);
        chk("rot0_ack", {ack3, ack2, ack1, ack0}, 4'b0001);
        set_gnt(4'b0010); din1 = 8'h22;
        tick();
        chk("rot1_data", out_data, 8'h22);
        chk("rot1_src", out_src, 1);
        chk("rot1_ack", {ack3, ack2, ack1, ack0}, 4'b0010);
        chk("rot1_cnt0", cnt0, 2);
        set_gnt(4'b0100); din2 = 8'h33;
        tick();
        chk("rot2_data", out_data, 8'h33);
        chk("rot2_src", out_src, 2);
        chk("rot2_ack", {ack3, ack2, ack1, ack0}, 4'b0100);
        chk("rot2_cnt1", cnt1, 1);
        set_gnt(4'b1000); din3 = 8'h44;
        tick();
        chk("rot3_data", out_data, 8'h44);
        chk("rot3_src", out_src, 3);
        chk("rot3_ack", {ack3, ack2, ack1, ack0}, 4'b1000);
        chk("rot3_cnt2", cnt2, 1);
        set_gnt(4'b0000);
        tick();
        chk("rot_drain", out_valid, 0);
        chk("rot_cnt3", cnt3, 1);

        // backpressure
        out_ready = 1'b0; set_gnt(4'b0001); din0 = 8'h55;
        tick();
        chk("bp_hold_data", out_data, 8'h55);
        chk("bp_hold_ack", {ack3, ack2, ack1, ack0}, 4'b0001);
        set_gnt(4'b0100); din2 = 8'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_ack", {ack3, ack2, ack1, ack0}, 0);
            chk("bp_stall_data", out_data, 8'h55);
            chk("bp_stall_src", out_src, 0);
            chk("bp_stall_valid", out_valid, 1);
        end
        chk("bp_stall_cnt0", cnt0, 2);
        out_ready = 1'b1;
        tick();
        chk("bp_swap_data", out_data, 8'h66);
        chk("bp_swap_src", out_src, 2);
        chk("bp_swap_ack", {ack3, ack2, ack1, ack0}, 4'b0100);
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_swap_cnt0", cnt0, 3);
        set_gnt(4'b0000);
        tick();
        chk("bp_drain", out_valid, 0);
        chk("bp_ack_once", {ack3, ack2, ack1, ack0}, 0);
        chk("bp_cnt2", cnt2, 2);

        // multi-hot
        set_gnt(4'b1010); din1 = 8'h77; din3 = 8'h88;
        tick();
        chk("multi_valid", out_valid, 0);
        chk("multi_ack", {ack3, ack2, ack1, ack0}, 0);
        chk("multi_err", err, 1);
        set_gnt(4'b0000);
        tick();
        chk("multi_sticky", err, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);

        // saturation: five transfers from source 3 with a 2-bit counter
        set_gnt(4'b1000);
        for (int i = 0; i < 5; i++) begin
            din3 = 8'(8'hC0 + i);
            tick();
            chk("sat_ack3", {ack3, ack2, ack1, ack0}, 4'b1000);
            chk("sat_data", out_data, 8'(8'hC0 + i));
        end
        set_gnt(4'b0000);
        tick();
        chk("sat_cnt3", cnt3, 3);
        chk("sat_others", {cnt2, cnt1, cnt0}, 0);

        // reset mid-transfer
        out_ready = 1'b0; set_gnt(4'b0001); din0 = 8'h99;
        tick();
        chk("mid_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_src", out_src, 0);
        chk("mid_rst_ack", {ack3, ack2, ack1, ack0}, 0);
        chk("mid_rst_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
